// File: rtl/logo_ctrl_pkg.sv
// Shared types and distance helpers for the logo position controller.
package logo_ctrl_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    S_SEARCH  = 2'd0,
    S_CONFIRM = 2'd1,
    S_MOVE    = 2'd2,
    S_HOLD    = 2'd3
  } logo_state_e;

  typedef struct packed {
    logo_state_e state;
    logic [7:0]  match;
  } logo_dbg_t;

  // Compare first so the subtraction never goes negative.
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic coord_t step_toward(input coord_t cur, input coord_t tgt,
                                         input coord_t step);
    coord_t d;
    d = abs_diff(cur, tgt);
    if (d > step) d = step;
    return (tgt >= cur) ? (cur + d) : (cur - d);
  endfunction

endpackage

// File: rtl/logo_pos_ctrl_if.sv
// Video/detector inputs and logo overlay outputs of the logo position controller.
interface logo_pos_ctrl_if #(
  parameter int LOGO_AW = 10
);
  import logo_ctrl_pkg::*;

  // No backpressure anywhere: video_in_valid qualifies cnt_x/cnt_y, det_hit
  // qualifies det_x/det_y, video_in_eop marks the last pixel of a frame, and
  // the consumer must take logo_draw/logo_addr on the cycle they are presented.
  logic               video_in_valid;
  logic               video_in_eop;
  coord_t             cnt_x;
  coord_t             cnt_y;
  logic               det_hit;
  coord_t             det_x;
  coord_t             det_y;
  coord_t             logo_x;
  coord_t             logo_y;
  logic               locked;
  logic               logo_draw;
  logic [LOGO_AW-1:0] logo_addr;

  modport slave (
    input  video_in_valid, video_in_eop, cnt_x, cnt_y, det_hit, det_x, det_y,
    output logo_x, logo_y, locked, logo_draw, logo_addr
  );

  modport master (
    output video_in_valid, video_in_eop, cnt_x, cnt_y, det_hit, det_x, det_y,
    input  logo_x, logo_y, locked, logo_draw, logo_addr
  );

endinterface

// File: rtl/logo_window_gen.sv
// Registered logo draw window and ROM address; window end clipped at 16'hFFFF.
module logo_window_gen
  import logo_ctrl_pkg::*;
#(
  parameter int LOGO_W  = 32,
  parameter int LOGO_H  = 32,
  parameter int LOGO_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable_i,
  input  logic               valid_i,
  input  coord_t             cnt_x_i,
  input  coord_t             cnt_y_i,
  input  coord_t             logo_x_i,
  input  coord_t             logo_y_i,
  output logic               draw_o,
  output logic [LOGO_AW-1:0] addr_o
);

  logic [COORD_W:0]   x_end;
  logic [COORD_W:0]   y_end;
  logic               in_x;
  logic               in_y;
  logic               draw_d;
  logic               draw_q;
  coord_t             dx;
  coord_t             dy;
  logic [31:0]        addr_full;
  logic [LOGO_AW-1:0] addr_d;
  logic [LOGO_AW-1:0] addr_q;
  logic               unused_addr_bits;

  // Ends carry one extra bit so a logo near 65535 clips instead of wrapping to 0.
  assign x_end = {1'b0, logo_x_i} + 17'(LOGO_W - 1);
  assign y_end = {1'b0, logo_y_i} + 17'(LOGO_H - 1);
  assign in_x  = (cnt_x_i >= logo_x_i) && ({1'b0, cnt_x_i} <= x_end);
  assign in_y  = (cnt_y_i >= logo_y_i) && ({1'b0, cnt_y_i} <= y_end);

  assign dx        = cnt_x_i - logo_x_i;
  assign dy        = cnt_y_i - logo_y_i;
  assign addr_full = 32'(dy) * 32'(LOGO_W) + 32'(dx);
  assign unused_addr_bits = ^addr_full[31:LOGO_AW];

  always_comb begin
    draw_d = enable_i & valid_i & in_x & in_y;
    addr_d = addr_q;
    if (draw_d) addr_d = addr_full[LOGO_AW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      draw_q <= 1'b0;
      addr_q <= '0;
    end else begin
      draw_q <= draw_d;
      addr_q <= addr_d;
    end
  end

  assign draw_o = draw_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/logo_pos_ctrl.sv
// Logo position controller: debounces marker detections per frame and glides the
// logo to the confirmed spot. Optional LOGO_LOST_EN adds a glide-home on marker loss.
module logo_pos_ctrl
  import logo_ctrl_pkg::*;
#(
  parameter int     LOGO_W      = 32,
  parameter int     LOGO_H      = 32,
  parameter int     LOGO_AW     = 10,
  parameter coord_t INIT_X      = 16'd10,
  parameter coord_t INIT_Y      = 16'd100,
  parameter int     CONFIRM     = 3,
  parameter int     TOL         = 2,
  parameter int     STEP        = 4,
  parameter int     LOST_FRAMES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  logo_pos_ctrl_if.slave  bus,
  output logo_dbg_t       dbg_o
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_MOVE    = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam coord_t     TOL_C     = coord_t'(TOL);
  localparam coord_t     STEP_C    = coord_t'(STEP);
  localparam logic [7:0] CONFIRM_C = 8'(CONFIRM);

  logic [1:0] state_q, state_d;
  logic [7:0] match_q, match_d;
  logic       seen_q, seen_d;
  coord_t     cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  coord_t     ref_x_q, ref_x_d, ref_y_q, ref_y_d;
  coord_t     tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  coord_t     logo_x_q, logo_x_d, logo_y_q, logo_y_d;

  logic       frame_seen;
  coord_t     frame_x;
  coord_t     frame_y;
  logic       agree_ref;
  logic       near_tgt;
  logic [7:0] match_inc;

`ifdef LOGO_LOST_EN
  localparam logic [7:0] LOST_C = 8'(LOST_FRAMES);
  logic [7:0] miss_q, miss_d;
  logic [7:0] miss_inc;
  assign miss_inc = miss_q + 8'd1;
`else
  localparam int UNUSED_LOST_FRAMES = LOST_FRAMES;
`endif

  // A hit on the eop cycle still belongs to the frame that is ending.
  assign frame_seen = seen_q | bus.det_hit;
  assign frame_x    = bus.det_hit ? bus.det_x : cand_x_q;
  assign frame_y    = bus.det_hit ? bus.det_y : cand_y_q;
  assign agree_ref  = (abs_diff(frame_x, ref_x_q) <= TOL_C) &&
                      (abs_diff(frame_y, ref_y_q) <= TOL_C);
  assign near_tgt   = (abs_diff(frame_x, tgt_x_q) <= TOL_C) &&
                      (abs_diff(frame_y, tgt_y_q) <= TOL_C);
  assign match_inc  = match_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    seen_d   = seen_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    ref_x_d  = ref_x_q;
    ref_y_d  = ref_y_q;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    logo_x_d = logo_x_q;
    logo_y_d = logo_y_q;
`ifdef LOGO_LOST_EN
    miss_d   = miss_q;
`endif

    if (bus.det_hit) begin
      cand_x_d = bus.det_x;
      cand_y_d = bus.det_y;
      seen_d   = 1'b1;
    end

    if (bus.video_in_eop) begin
      seen_d = 1'b0;
`ifdef LOGO_LOST_EN
      miss_d = '0;
`endif
      if (!enable) begin
        state_d = ST_SEARCH;
        match_d = '0;
      end else begin
        case (state_q)
          ST_SEARCH: begin
            if (frame_seen) begin
              ref_x_d = frame_x;
              ref_y_d = frame_y;
              match_d = 8'd1;
              if (CONFIRM == 1) begin
                tgt_x_d = frame_x;
                tgt_y_d = frame_y;
                state_d = ST_MOVE;
              end else begin
                state_d = ST_CONFIRM;
              end
            end else begin
              match_d = '0;
            end
          end
          ST_CONFIRM: begin
            if (!frame_seen) begin
              state_d = ST_SEARCH;
              match_d = '0;
            end else if (agree_ref) begin
              match_d = match_inc;
              if (match_inc >= CONFIRM_C) begin
                tgt_x_d = ref_x_q;
                tgt_y_d = ref_y_q;
                state_d = ST_MOVE;
              end
            end else begin
              ref_x_d = frame_x;
              ref_y_d = frame_y;
              match_d = 8'd1;
            end
          end
          ST_MOVE: begin
            logo_x_d = step_toward(logo_x_q, tgt_x_q, STEP_C);
            logo_y_d = step_toward(logo_y_q, tgt_y_q, STEP_C);
            if ((logo_x_d == tgt_x_q) && (logo_y_d == tgt_y_q)) state_d = ST_HOLD;
          end
          default: begin
            if (frame_seen && !near_tgt) begin
              ref_x_d = frame_x;
              ref_y_d = frame_y;
              match_d = 8'd1;
              state_d = ST_CONFIRM;
            end
`ifdef LOGO_LOST_EN
            else if (!frame_seen) begin
              if (miss_inc >= LOST_C) begin
                tgt_x_d = INIT_X;
                tgt_y_d = INIT_Y;
                state_d = ST_MOVE;
              end else begin
                miss_d = miss_inc;
              end
            end
`endif
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SEARCH;
      match_q  <= '0;
      seen_q   <= 1'b0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      ref_x_q  <= '0;
      ref_y_q  <= '0;
      tgt_x_q  <= INIT_X;
      tgt_y_q  <= INIT_Y;
      logo_x_q <= INIT_X;
      logo_y_q <= INIT_Y;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      seen_q   <= seen_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      ref_x_q  <= ref_x_d;
      ref_y_q  <= ref_y_d;
      tgt_x_q  <= tgt_x_d;
      tgt_y_q  <= tgt_y_d;
      logo_x_q <= logo_x_d;
      logo_y_q <= logo_y_d;
    end
  end

`ifdef LOGO_LOST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) miss_q <= '0;
    else     miss_q <= miss_d;
  end
`endif

  logic               draw_w;
  logic [LOGO_AW-1:0] addr_w;

  logo_window_gen #(
    .LOGO_W  (LOGO_W),
    .LOGO_H  (LOGO_H),
    .LOGO_AW (LOGO_AW)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .enable_i (enable),
    .valid_i  (bus.video_in_valid),
    .cnt_x_i  (bus.cnt_x),
    .cnt_y_i  (bus.cnt_y),
    .logo_x_i (logo_x_q),
    .logo_y_i (logo_y_q),
    .draw_o   (draw_w),
    .addr_o   (addr_w)
  );

  assign bus.logo_x    = logo_x_q;
  assign bus.logo_y    = logo_y_q;
  assign bus.locked    = (state_q == ST_HOLD);
  assign bus.logo_draw = draw_w;
  assign bus.logo_addr = addr_w;

  always_comb begin
    dbg_o.state = logo_state_e'(state_q);
    dbg_o.match = match_q;
  end

endmodule

// File: tb/tb_logo_pos_ctrl.sv
// Scoreboard bench for logo_pos_ctrl: expectations are queued with a due cycle and
// checked by a separate negedge monitor.
module tb_logo_pos_ctrl;
  import logo_ctrl_pkg::*;

  typedef struct {
    int due;
    int kind;
    int val;
  } exp_t;

  localparam int K_DRAW  = 0;
  localparam int K_ADDR  = 1;
  localparam int K_LX    = 2;
  localparam int K_LY    = 3;
  localparam int K_LOCK  = 4;
  localparam int K_STATE = 5;
  localparam int K_MATCH = 6;
  localparam int K_EDRAW = 7;
  localparam int K_EADDR = 8;

  string kind_name[9] = '{"draw", "addr", "logo_x", "logo_y", "locked", "state",
                          "match", "edge_draw", "edge_addr"};

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic enable_e;
  int   cyc = 0;
  int   tests_run = 0;
  int   fail_cnt = 0;
  exp_t exp_q[$];
  exp_t keep_q[$];
  logo_dbg_t dbg;
  logo_dbg_t dbg_e;

  logo_pos_ctrl_if #(.LOGO_AW(10)) bus ();
  logo_pos_ctrl_if #(.LOGO_AW(10)) bus_e ();

  logo_pos_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .bus    (bus),
    .dbg_o  (dbg)
  );

  logo_pos_ctrl #(.INIT_X(16'hFFF0), .INIT_Y(16'd0)) dut_e (
    .clk    (clk),
    .rst    (rst),
    .enable (enable_e),
    .bus    (bus_e),
    .dbg_o  (dbg_e)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int actual(input int k);
    case (k)
      K_DRAW:  return int'(bus.logo_draw);
      K_ADDR:  return int'(bus.logo_addr);
      K_LX:    return int'(bus.logo_x);
      K_LY:    return int'(bus.logo_y);
      K_LOCK:  return int'(bus.locked);
      K_STATE: return int'(dbg.state);
      K_MATCH: return int'(dbg.match);
      K_EDRAW: return int'(bus_e.logo_draw);
      default: return int'(bus_e.logo_addr);
    endcase
  endfunction

  // monitor: pops every expectation due this cycle
  always @(negedge clk) begin
    keep_q = {};
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc) begin
        tests_run++;
        if (actual(exp_q[i].kind) != exp_q[i].val) begin
          fail_cnt++;
          $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                   kind_name[exp_q[i].kind], actual(exp_q[i].kind), exp_q[i].val, cyc);
        end
      end else if (exp_q[i].due < cyc) begin
        tests_run++;
        fail_cnt++;
        $display("FAIL %s: expectation never checked, due cycle %0d", kind_name[exp_q[i].kind],
                 exp_q[i].due);
      end else begin
        keep_q.push_back(exp_q[i]);
      end
    end
    exp_q = keep_q;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int val, input int dly);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic win(input logic v, input int x, input int y, input int ed, input int ea);
    bus.video_in_valid = v;
    bus.cnt_x = 16'(x);
    bus.cnt_y = 16'(y);
    push(K_DRAW, ed, 1);
    if (ea >= 0) push(K_ADDR, ea, 1);
    tick();
  endtask

  task automatic ewin(input int x, input int y, input int ed, input int ea);
    bus_e.video_in_valid = 1'b1;
    bus_e.cnt_x = 16'(x);
    bus_e.cnt_y = 16'(y);
    push(K_EDRAW, ed, 1);
    push(K_EADDR, ea, 1);
    tick();
  endtask

  task automatic frame(input logic hit, input int hx, input int hy, input logic on_eop,
                       input int ex, input int ey, input int elk, input int est,
                       input int emt);
    bus.det_x = 16'(hx);
    bus.det_y = 16'(hy);
    bus.det_hit = hit & ~on_eop;
    bus.video_in_eop = 1'b0;
    tick();
    bus.det_hit = hit & on_eop;
    bus.video_in_eop = 1'b1;
    push(K_LX, ex, 1);
    push(K_LY, ey, 1);
    push(K_LOCK, elk, 1);
    push(K_STATE, est, 1);
    if (emt >= 0) push(K_MATCH, emt, 1);
    tick();
    bus.det_hit = 1'b0;
    bus.video_in_eop = 1'b0;
  endtask

  initial begin
    int ex;
    int ey;
    rst = 1'b1;
    enable = 1'b1;
    enable_e = 1'b1;
    bus.video_in_valid = 1'b0;
    bus.video_in_eop = 1'b0;
    bus.cnt_x = '0;
    bus.cnt_y = '0;
    bus.det_hit = 1'b0;
    bus.det_x = '0;
    bus.det_y = '0;
    bus_e.video_in_valid = 1'b0;
    bus_e.video_in_eop = 1'b0;
    bus_e.cnt_x = '0;
    bus_e.cnt_y = '0;
    bus_e.det_hit = 1'b0;
    bus_e.det_x = '0;
    bus_e.det_y = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset mid-frame, with a pending detection and draw active
    bus.video_in_valid = 1'b1;
    bus.cnt_x = 16'd10;
    bus.cnt_y = 16'd100;
    bus.det_hit = 1'b1;
    bus.det_x = 16'd200;
    bus.det_y = 16'd50;
    push(K_DRAW, 1, 1);
    push(K_ADDR, 0, 1);
    tick();
    tick();
    bus.det_hit = 1'b0;
    bus.video_in_valid = 1'b0;
    rst = 1'b1;
    push(K_DRAW, 0, 0);
    push(K_ADDR, 0, 0);
    push(K_LX, 10, 0);
    push(K_LY, 100, 0);
    push(K_LOCK, 0, 0);
    push(K_STATE, S_SEARCH, 0);
    push(K_MATCH, 0, 0);
    tick();
    rst = 1'b0;
    frame(1'b0, 0, 0, 1'b0, 10, 100, 0, S_SEARCH, 0);

    // draw window around the reset position
    win(1'b1, 10, 100, 1, 0);
    win(1'b1, 41, 131, 1, 1023);
    win(1'b1, 42, 100, 0, 1023);
    win(1'b1, 9, 100, 0, 1023);
    win(1'b1, 41, 132, 0, 1023);
    win(1'b1, 20, 101, 1, 42);
    win(1'b0, 10, 100, 0, -1);
    enable = 1'b0;
    win(1'b1, 10, 100, 0, -1);
    enable = 1'b1;
    bus.video_in_valid = 1'b0;

    // window clipped at the top of the coordinate range
    ewin(65535, 0, 1, 15);
    ewin(0, 0, 0, 15);
    ewin(65520, 31, 1, 992);
    ewin(65519, 0, 0, 992);
    ewin(65535, 32, 0, 992);
    bus_e.video_in_valid = 1'b0;

    // confirm over three frames, last hit on the eop cycle
    frame(1'b1, 200, 50, 1'b0, 10, 100, 0, S_CONFIRM, 1);
    frame(1'b1, 201, 51, 1'b0, 10, 100, 0, S_CONFIRM, 2);
    frame(1'b1, 200, 50, 1'b1, 10, 100, 0, S_MOVE, -1);

    // glide toward (200,50), detections ignored while moving
    for (int n = 1; n <= 48; n++) begin
      ex = (10 + 4 * n > 200) ? 200 : 10 + 4 * n;
      ey = (100 - 4 * n < 50) ? 50 : 100 - 4 * n;
      frame(n == 5, 500, 500, 1'b0, ex, ey, (n == 48) ? 1 : 0,
            (n == 48) ? S_HOLD : S_MOVE, -1);
    end

    // tolerance boundaries in HOLD and CONFIRM
    frame(1'b1, 202, 48, 1'b0, 200, 50, 1, S_HOLD, -1);
    frame(1'b1, 203, 50, 1'b0, 200, 50, 0, S_CONFIRM, 1);
    frame(1'b1, 205, 52, 1'b0, 200, 50, 0, S_CONFIRM, 2);
    frame(1'b1, 208, 52, 1'b0, 200, 50, 0, S_CONFIRM, 1);
    frame(1'b1, 206, 50, 1'b0, 200, 50, 0, S_CONFIRM, 2);
    frame(1'b0, 0, 0, 1'b0, 200, 50, 0, S_SEARCH, 0);

    // enable low forces SEARCH, position retained
    frame(1'b1, 210, 60, 1'b0, 200, 50, 0, S_CONFIRM, 1);
    enable = 1'b0;
    frame(1'b1, 210, 60, 1'b0, 200, 50, 0, S_SEARCH, 0);
    enable = 1'b1;

    // re-lock at (202,52), then frames with no detection
    frame(1'b1, 202, 52, 1'b0, 200, 50, 0, S_CONFIRM, 1);
    frame(1'b1, 202, 52, 1'b0, 200, 50, 0, S_CONFIRM, 2);
    frame(1'b1, 202, 52, 1'b0, 200, 50, 0, S_MOVE, -1);
    frame(1'b0, 0, 0, 1'b0, 202, 52, 1, S_HOLD, -1);
    for (int k = 1; k <= 10; k++) begin
`ifdef LOGO_LOST_EN
      if (k < 8)       frame(1'b0, 0, 0, 1'b0, 202, 52, 1, S_HOLD, -1);
      else if (k == 8) frame(1'b0, 0, 0, 1'b0, 202, 52, 0, S_MOVE, -1);
      else             frame(1'b0, 0, 0, 1'b0, 202 - 4 * (k - 8), 52 + 4 * (k - 8), 0,
                             S_MOVE, -1);
`else
      frame(1'b0, 0, 0, 1'b0, 202, 52, 1, S_HOLD, -1);
`endif
    end

    repeat (4) tick();
    if (exp_q.size() != 0) begin
      tests_run++;
      fail_cnt++;
      $display("FAIL leftover: %0d expectations unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
